// File: rtl/serial_adder.sv
// ============================================================================
// serial_adder
// ----------------------------------------------------------------------------
// Bit-serial WIDTH-bit unsigned adder. The two operands are captured through
// a valid/ready handshake. The block then adds them LSB-first, one bit per
// clock, using two half-adder cells and a carry flip-flop. The sum and the
// carry-out are handed off through a second valid/ready handshake.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst_n        in   1      asynchronous reset, active low
//   in_valid_i   in   1      operands a_i/b_i valid
//   in_ready_o   out  1      operands can be accepted (IDLE only)
//   a_i, b_i     in   WIDTH  operands, sampled on the accept edge only
//   out_valid_o  out  1      sum_o/carry_out_o valid (DONE only)
//   out_ready_i  in   1      downstream accepts the result
//   sum_o        out  WIDTH  (a+b) mod 2^WIDTH
//   carry_out_o  out  1      carry out of bit WIDTH-1
//   busy_o       out  1      high in RUN and DONE
// ============================================================================
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o,
   output logic             busy_o
);

   // Counter holds 0..WIDTH without wrapping, for every legal WIDTH.
   localparam int                CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Half-adder cell: returns {carry, sum}.
   function automatic logic [1:0] half_add(input logic x, input logic y);
      return {x & y, x ^ y};
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       ha0_s;
   logic [1:0]       ha1_s;
   logic             bit_sum_s;
   logic             bit_carry_s;

   // Full-adder slice built from two half adders plus an OR for the carry.
   always_comb begin
      ha0_s       = half_add(a_q[0], b_q[0]);
      ha1_s       = half_add(ha0_s[0], carry_q);
      bit_sum_s   = ha1_s[0];
      bit_carry_s = ha0_s[1] | ha1_s[1];
   end

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid_i) begin
               a_d     = a_i;
               b_d     = b_i;
               sum_d   = '0;
               carry_d = 1'b0;
               cout_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Each new sum bit enters at the MSB; after WIDTH shifts the
            // first (LSB) bit has reached position 0.
            sum_d            = sum_q >> 1;
            sum_d[WIDTH-1]   = bit_sum_s;
            a_d              = a_q >> 1;
            b_d              = b_q >> 1;
            carry_d          = bit_carry_s;
            cnt_d            = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               cout_d  = bit_carry_s;
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (out_ready_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake and status flags are pure decodes of the state register.
   assign in_ready_o  = (state_q == ST_IDLE);
   assign out_valid_o = (state_q == ST_DONE);
   assign busy_o      = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign sum_o       = sum_q;
   assign carry_out_o = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ============================================================================
// tb_serial_adder
// ----------------------------------------------------------------------------
// Directed self-checking bench for serial_adder. One instance with WIDTH=8
// and one with WIDTH=1 share the clock and reset.
// ============================================================================
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       v8 = 1'b0, rdy8, ov8, ordy8 = 1'b1, co8, busy8;
   logic [7:0] a8 = 8'h00, b8 = 8'h00, s8;

   logic       v1 = 1'b0, rdy1, ov1, ordy1 = 1'b1, co1, busy1;
   logic [0:0] a1 = 1'b0, b1 = 1'b0, s1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(v8), .in_ready_o(rdy8), .a_i(a8), .b_i(b8),
      .out_valid_o(ov8), .out_ready_i(ordy8),
      .sum_o(s8), .carry_out_o(co8), .busy_o(busy8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid_i(v1), .in_ready_o(rdy1), .a_i(a1), .b_i(b1),
      .out_valid_o(ov1), .out_ready_i(ordy1),
      .sum_o(s1), .carry_out_o(co1), .busy_o(busy1)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present operands to the 8-bit instance and let them be accepted.
   task automatic start8(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      a8 = a; b8 = b; v8 = 1'b1;
      @(posedge clk); #1;
      v8 = 1'b0;
   endtask

   // Count edges after accept until out_valid, bounded.
   task automatic wait8(output int lat);
      lat = 0;
      while (!ov8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Full transaction with out_ready high, including the handoff edge.
   task automatic txn8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] es, input logic ec);
      int lat;
      start8(a, b);
      wait8(lat);
      check({tag, "_lat"},  32'(lat), 32'd8);
      check({tag, "_sum"},  32'(s8),  32'(es));
      check({tag, "_cout"}, 32'(co8), 32'(ec));
      @(posedge clk); #1;
      check({tag, "_ov_after"}, 32'(ov8),  32'd0);
      check({tag, "_rdy_after"}, 32'(rdy8), 32'd1);
   endtask

   // One-bit instance transaction: result one cycle after accept.
   task automatic txn1(input logic a, input logic b);
      int lat;
      @(negedge clk);
      a1 = a; b1 = b; v1 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check($sformatf("w1_%0d%0d_lat", a, b), 32'(lat), 32'd1);
      check($sformatf("w1_%0d%0d_res", a, b), 32'({co1, s1}), 32'(a) + 32'(b));
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      logic [7:0] held_s;

      // Reset state
      #12;
      check("rst_sum",  32'(s8),    32'd0);
      check("rst_cout", 32'(co8),   32'd0);
      check("rst_ov",   32'(ov8),   32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_rdy",  32'(rdy8),  32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic additions: 3C+A5=E1, FF+01 wraps with carry, 0+0, 80+80
      txn8("t1",  8'h3C, 8'hA5, 8'hE1, 1'b0);
      txn8("t2",  8'hFF, 8'h01, 8'h00, 1'b1);
      txn8("t2z", 8'h00, 8'h00, 8'h00, 1'b0);
      txn8("t2m", 8'h80, 8'h80, 8'h00, 1'b1);

      // Back-pressure: C8+64 = 0x12C held through 5 stalled cycles
      ordy8 = 1'b0;
      start8(8'hC8, 8'h64);
      check("bp_busy_run", 32'(busy8), 32'd1);
      wait8(lat);
      check("bp_lat", 32'(lat), 32'd8);
      held_s = s8;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp_sum_%0d", i), 32'(s8), 32'h2C);
         check($sformatf("bp_cout_%0d", i), 32'(co8), 32'd1);
         check($sformatf("bp_ov_%0d", i), 32'(ov8), 32'd1);
         check($sformatf("bp_rdy_%0d", i), 32'(rdy8), 32'd0);
      end
      check("bp_stable", 32'(s8), 32'(held_s));
      @(negedge clk);
      ordy8 = 1'b1;
      @(posedge clk); #1;
      check("bp_ov_release",  32'(ov8),  32'd0);
      check("bp_rdy_release", 32'(rdy8), 32'd1);

      // in_valid pulsed during RUN with new operands must be ignored
      start8(8'h12, 8'h34);
      @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
      check("ign_rdy", 32'(rdy8), 32'd0);
      @(posedge clk); #1;
      v8 = 1'b0;
      wait8(lat);
      check("ign_lat",  32'(lat) + 32'd1, 32'd8);
      check("ign_sum",  32'(s8),  32'h46);
      check("ign_cout", 32'(co8), 32'd0);
      @(posedge clk); #1;

      // Reset mid-RUN after four processed bits
      start8(8'hAA, 8'h55);
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("abort_busy_pre", 32'(busy8), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_ov",   32'(ov8),   32'd0);
      check("abort_busy", 32'(busy8), 32'd0);
      check("abort_rdy",  32'(rdy8),  32'd1);
      check("abort_sum",  32'(s8),    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      txn8("post", 8'h7F, 8'h01, 8'h80, 1'b0);

      // WIDTH=1 exhaustive
      for (int i = 0; i < 4; i++) begin
         txn1(i[1], i[0]);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
